servo_cmd_ctrl: RTL and testbench
=================================

// Module: servo_cmd_ctrl
// PURPOSE
// - Command controller between uart_rx/uart_tx and servo_control.
// - Assembles 3-byte UART frames {CMD, DATA_HI, DATA_LO} from rx valid strobes.
// - Validates and clamps the request, then drives the servo pulse-width register.
// - Sequences a 4-byte reply {STATUS, HI, LO, 0x0A} through the tx busy handshake.
// PARAMETERS
// - CLK_PER_US   27      clk cycles per microsecond (27 MHz board clock)
// - MIN_US       500     lowest accepted pulse, us
// - MAX_US       2500    highest accepted pulse, us
// - DEFAULT_US   1500    pulse applied at reset, us
// - TIMEOUT_CYC  270000  max gap between bytes of one frame (10 ms)
// - PULSE_W      20      width of o_pulse_cyc
// PORTS
// - clk           in   1        system clock
// - i_resetn      in   1        synchronous reset, active low
// - i_rx_valid    in   1        1-cycle strobe from uart_rx: byte available
// - i_rx_data     in   8        byte from uart_rx, valid with i_rx_valid
// - i_tx_busy     in   1        uart_tx busy flag
// - o_tx_en       out  1        1-cycle start strobe to uart_tx
// - o_tx_data     out  8        byte to uart_tx, stable from o_tx_en until busy falls
// - o_pulse_cyc   out  PULSE_W  servo high time in clk cycles (to servo_control)
// - o_pulse_upd   out  1        1-cycle strobe: o_pulse_cyc changed
// - o_status      out  8        status of the last frame (drives control_leds)
// - o_overrun     out  1        sticky: byte dropped while replying
// BEHAVIOUR
// - Reset (i_resetn=0 at a clk edge) takes priority over all else and aborts any frame or reply mid-way.
// - Reset values: o_pulse_cyc=DEFAULT_US*CLK_PER_US, o_status=0x00; all other outputs 0; FSM=IDLE; timer=0.
// - FSM states: IDLE, GOT_CMD, GOT_HI, EXEC, TX_LOAD, TX_WAIT_HI, TX_WAIT_LO.
// - IDLE: on i_rx_valid, latch CMD and go to GOT_CMD.
// - GOT_CMD: on i_rx_valid, latch HI and go to GOT_HI.
// - GOT_HI: on i_rx_valid, latch LO and go to EXEC.
// - Inter-byte timeout: timer clears on every accepted byte and counts in GOT_CMD/GOT_HI.
//   - At TIMEOUT_CYC-1: STATUS=0xE1, HI/LO=0x00, go to TX_LOAD.
// - EXEC (one cycle); v={HI,LO}, unsigned:
//   - CMD 0x01 SET: clamp v to [MIN_US,MAX_US].
//     - o_pulse_cyc <= clamped*CLK_PER_US (PULSE_W-bit product, no truncation at defaults); o_pulse_upd=1 for one cycle.
//     - STATUS=0x00 if unclamped, else 0x01; reply HI/LO = clamped value.
//   - CMD 0x02 GET: reply current o_pulse_cyc/CLK_PER_US (constant division), STATUS=0x00, no update.
//   - Any other CMD: STATUS=0xEE, reply HI/LO=0x00, no update.
//   - o_status<=STATUS. Next state TX_LOAD.
// - Latency: third byte strobe at cycle N -> o_pulse_cyc/o_pulse_upd at N+2; first o_tx_en no earlier than N+2.
// - Reply sequencing: byte index k=0..3 selects {STATUS, HI, LO, 0x0A}.
//   - TX_LOAD: when i_tx_busy==0, drive o_tx_data and o_tx_en=1 for one cycle, go to TX_WAIT_HI.
//   - TX_WAIT_HI: wait for i_tx_busy==1. If busy does not rise within 4 cycles, treat the byte as sent.
//   - TX_WAIT_LO: wait for i_tx_busy==0. Then k++ and go to TX_LOAD, or to IDLE after k=3.
//   - o_tx_en is never asserted while i_tx_busy==1.
// - i_rx_valid in EXEC or any TX_* state: byte discarded, o_overrun<=1 (cleared only by reset).
// - A byte strobe in the same cycle as the timeout: the byte wins, the timer clears, no timeout.
// STRUCTURE
// - servo_cmd_defs.vh holds the shared constants:
//   - command codes 0x01/0x02, status codes 0x00/0x01/0xE1/0xEE, terminator 0x0A
//   - FSM state encodings (3-bit)
// - One sub-module, reply_serializer: 4-byte reply buffer + tx handshake (TX_* states), start/done ports.
// - Parent keeps frame assembly, timeout, EXEC arithmetic and the pulse register.
// TESTING
// - Reset release: o_pulse_cyc=40500, o_tx_en=0, o_status=0x00, o_overrun=0.
// - Frame 01 07 D0 (2000 us): o_pulse_cyc=54000 at N+2 with a 1-cycle o_pulse_upd.
//   - Reply 00 07 D0 0A, each o_tx_en only while busy=0.
// - Frame 01 00 64 (100 us): clamp -> o_pulse_cyc=13500, reply 01 01 F4 0A, o_status=0x01.
// - Frame 02 xx xx after the previous set: no o_pulse_upd, reply 00 01 F4 0A.
// - Bytes 01 07 then 270000 idle cycles: reply E1 00 00 0A, o_pulse_cyc unchanged.
//   - Byte arriving at cycle 269999: no timeout.
// - Frame 55 00 00: reply EE 00 00 0A.
//   - Extra byte during the reply: o_overrun=1, next frame still parsed correctly.
// - i_resetn=0 mid-reply (after byte 1): o_tx_en stays 0 and the FSM returns to IDLE.
//   - The next frame is accepted normally.

Source files
------------

// File: rtl/servo_cmd_ctrl_pkg.sv
// Shared definitions for the servo command controller.
// Holds the command codes, reply status codes, the reply terminator byte,
// the 3-bit FSM state encodings and the request clamp helper.
package servo_cmd_ctrl_pkg;

    typedef logic [2:0] state_t;

    // Command codes (first byte of a frame)
    localparam logic [7:0] CMD_SET = 8'h01;
    localparam logic [7:0] CMD_GET = 8'h02;

    // Status codes (first byte of a reply, also shown on o_status)
    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_CLAMPED = 8'h01;
    localparam logic [7:0] ST_TIMEOUT = 8'hE1;
    localparam logic [7:0] ST_BAD_CMD = 8'hEE;

    // Last byte of every reply
    localparam logic [7:0] REPLY_TERM = 8'h0A;

    // FSM state encodings
    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_GOT_CMD    = 3'd1;
    localparam logic [2:0] S_GOT_HI     = 3'd2;
    localparam logic [2:0] S_EXEC       = 3'd3;
    localparam logic [2:0] S_TX_LOAD    = 3'd4;
    localparam logic [2:0] S_TX_WAIT_HI = 3'd5;
    localparam logic [2:0] S_TX_WAIT_LO = 3'd6;

    // Clamp an unsigned request into [lo_lim, hi_lim]
    function automatic logic [15:0] clamp_us(input logic [15:0] v,
                                             input logic [15:0] lo_lim,
                                             input logic [15:0] hi_lim);
        if (v < lo_lim) return lo_lim;
        if (v > hi_lim) return hi_lim;
        return v;
    endfunction

endpackage

// File: rtl/servo_cmd_ctrl_if.sv
// Bus between servo_cmd_ctrl and its surroundings (uart_rx, uart_tx,
// servo_control, control_leds).
//   i_rx_valid/i_rx_data : byte strobe from uart_rx (1-cycle, no backpressure)
//   i_tx_busy            : uart_tx busy flag
//   o_tx_en/o_tx_data    : start strobe and byte to uart_tx
//   o_pulse_cyc/_upd     : servo high time in clk cycles and its change strobe
//   o_status, o_overrun  : last frame status, sticky dropped-byte flag
//   dbg_state            : current FSM state (parent or serializer phase)
// Handshake: o_tx_en is a 1-cycle strobe issued only while i_tx_busy is low;
// o_tx_data holds from that strobe until busy falls again. The rx side has
// no ready: a strobe that arrives while the controller cannot take it is
// dropped and recorded in o_overrun.
// master = the controller, slave = the environment.
interface servo_cmd_ctrl_if #(
    parameter int PULSE_W = 20
);
    import servo_cmd_ctrl_pkg::*;

    logic               i_rx_valid;
    logic [7:0]         i_rx_data;
    logic               i_tx_busy;
    logic               o_tx_en;
    logic [7:0]         o_tx_data;
    logic [PULSE_W-1:0] o_pulse_cyc;
    logic               o_pulse_upd;
    logic [7:0]         o_status;
    logic               o_overrun;
    state_t             dbg_state;

    modport master (
        input  i_rx_valid, i_rx_data, i_tx_busy,
        output o_tx_en, o_tx_data, o_pulse_cyc, o_pulse_upd, o_status,
               o_overrun, dbg_state
    );

    modport slave (
        output i_rx_valid, i_rx_data, i_tx_busy,
        input  o_tx_en, o_tx_data, o_pulse_cyc, o_pulse_upd, o_status,
               o_overrun, dbg_state
    );

endinterface

// File: rtl/servo_cmd_ctrl_reply_serializer.sv
// Sends the 4-byte reply {status, hi, lo, 0x0A} to uart_tx.
//   clk, i_resetn : clock, synchronous active-low reset
//   start         : 1-cycle strobe, latches status/hi/lo (accepted in idle only)
//   tx_busy       : uart_tx busy flag
//   tx_en/tx_data : start strobe and byte to uart_tx
//   done          : 1-cycle strobe in the cycle the last byte completes
//   state         : serializer state (S_IDLE or one of the S_TX_* codes)
module servo_cmd_ctrl_reply_serializer
    import servo_cmd_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       i_resetn,
    input  logic       start,
    input  logic [7:0] status,
    input  logic [7:0] hi,
    input  logic [7:0] lo,
    input  logic       tx_busy,
    output logic       tx_en,
    output logic [7:0] tx_data,
    output logic       done,
    output state_t     state
);

    state_t     state_q;
    logic [1:0] idx;
    logic [1:0] wait_cnt;
    logic [7:0] byte_buf [4];

    // tx_en is combinational so it can never coincide with busy; it is also
    // gated by reset so a reset in the middle of a reply emits nothing.
    assign tx_en   = i_resetn && (state_q == S_TX_LOAD) && !tx_busy;
    assign tx_data = byte_buf[idx];
    assign done    = (state_q == S_TX_WAIT_LO) && !tx_busy && (idx == 2'd3);
    assign state   = state_q;

    always_ff @(posedge clk) begin
        if (!i_resetn) begin
            state_q  <= S_IDLE;
            idx      <= 2'd0;
            wait_cnt <= 2'd0;
            byte_buf <= '{default: 8'h00};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        byte_buf <= '{status, hi, lo, REPLY_TERM};
                        idx      <= 2'd0;
                        state_q  <= S_TX_LOAD;
                    end
                end
                S_TX_LOAD: begin
                    if (!tx_busy) begin
                        wait_cnt <= 2'd0;
                        state_q  <= S_TX_WAIT_HI;
                    end
                end
                S_TX_WAIT_HI: begin
                    // A uart_tx that never raises busy must not stall the
                    // reply: after 4 cycles the byte counts as sent.
                    if (tx_busy || wait_cnt == 2'd3) begin
                        state_q <= S_TX_WAIT_LO;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                S_TX_WAIT_LO: begin
                    if (!tx_busy) begin
                        if (idx == 2'd3) begin
                            state_q <= S_IDLE;
                        end else begin
                            idx     <= idx + 2'd1;
                            state_q <= S_TX_LOAD;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/servo_cmd_ctrl.sv
// Command controller between uart_rx/uart_tx and servo_control.
// Assembles {CMD, HI, LO} frames, enforces an inter-byte timeout, executes
// SET/GET on the pulse-width register and hands a 4-byte reply to the
// serializer.
//   clk      : system clock
//   i_resetn : synchronous reset, active low
//   bus      : servo_cmd_ctrl_if master (rx strobe, tx handshake, pulse,
//              status, overrun, debug state)
module servo_cmd_ctrl
    import servo_cmd_ctrl_pkg::*;
#(
    parameter int CLK_PER_US  = 27,
    parameter int MIN_US      = 500,
    parameter int MAX_US      = 2500,
    parameter int DEFAULT_US  = 1500,
    parameter int TIMEOUT_CYC = 270000,
    parameter int PULSE_W     = 20
) (
    input  logic            clk,
    input  logic            i_resetn,
    servo_cmd_ctrl_if.master bus
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);

    // While a reply is in flight the parent parks in S_TX_LOAD and the
    // serializer owns the detailed TX_* sequencing.
    state_t             state;
    logic [7:0]         cmd, hi, lo;
    logic [TW-1:0]      timer;
    logic [PULSE_W-1:0] pulse_cyc;
    logic               pulse_upd;
    logic [7:0]         status_q;
    logic               overrun;

    logic [15:0]        req_us, clamped_us, cur_us;
    logic [PULSE_W-1:0] set_cyc;
    logic               in_frame, accepting, timeout_hit, start, reply_done;
    logic [7:0]         rep_status, rep_hi, rep_lo;
    state_t             ser_state;

    assign req_us     = {hi, lo};
    assign clamped_us = clamp_us(req_us, 16'(MIN_US), 16'(MAX_US));
    assign set_cyc    = PULSE_W'(clamped_us) * PULSE_W'(CLK_PER_US);
    assign cur_us     = 16'(pulse_cyc / PULSE_W'(CLK_PER_US));

    assign in_frame    = (state == S_GOT_CMD) || (state == S_GOT_HI);
    assign accepting   = (state == S_IDLE) || in_frame;
    // A byte in the same cycle as the last timer count wins over the timeout.
    assign timeout_hit = in_frame && !bus.i_rx_valid && (timer == TIMEOUT_LAST);
    assign start       = (state == S_EXEC) || timeout_hit;

    always_comb begin
        rep_status = ST_OK;
        rep_hi     = 8'h00;
        rep_lo     = 8'h00;
        if (state == S_EXEC) begin
            case (cmd)
                CMD_SET: begin
                    rep_status       = (clamped_us != req_us) ? ST_CLAMPED : ST_OK;
                    {rep_hi, rep_lo} = clamped_us;
                end
                CMD_GET: {rep_hi, rep_lo} = cur_us;
                default: rep_status = ST_BAD_CMD;
            endcase
        end else if (timeout_hit) begin
            rep_status = ST_TIMEOUT;
        end
    end

    always_ff @(posedge clk) begin
        if (!i_resetn) begin
            state     <= S_IDLE;
            cmd       <= 8'h00;
            hi        <= 8'h00;
            lo        <= 8'h00;
            timer     <= '0;
            pulse_cyc <= PULSE_W'(DEFAULT_US * CLK_PER_US);
            pulse_upd <= 1'b0;
            status_q  <= ST_OK;
            overrun   <= 1'b0;
        end else begin
            pulse_upd <= 1'b0;
            if (bus.i_rx_valid && !accepting) overrun <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (bus.i_rx_valid) begin
                        cmd   <= bus.i_rx_data;
                        timer <= '0;
                        state <= S_GOT_CMD;
                    end
                end
                S_GOT_CMD, S_GOT_HI: begin
                    if (bus.i_rx_valid) begin
                        if (state == S_GOT_CMD) begin
                            hi    <= bus.i_rx_data;
                            state <= S_GOT_HI;
                        end else begin
                            lo    <= bus.i_rx_data;
                            state <= S_EXEC;
                        end
                        timer <= '0;
                    end else if (timeout_hit) begin
                        // An abandoned frame is still the last frame seen.
                        status_q <= ST_TIMEOUT;
                        state    <= S_TX_LOAD;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_EXEC: begin
                    if (cmd == CMD_SET) begin
                        pulse_cyc <= set_cyc;
                        pulse_upd <= 1'b1;
                    end
                    status_q <= rep_status;
                    state    <= S_TX_LOAD;
                end
                default: begin
                    if (reply_done) state <= S_IDLE;
                end
            endcase
        end
    end

    servo_cmd_ctrl_reply_serializer u_reply (
        .clk      (clk),
        .i_resetn (i_resetn),
        .start    (start),
        .status   (rep_status),
        .hi       (rep_hi),
        .lo       (rep_lo),
        .tx_busy  (bus.i_tx_busy),
        .tx_en    (bus.o_tx_en),
        .tx_data  (bus.o_tx_data),
        .done     (reply_done),
        .state    (ser_state)
    );

    assign bus.o_pulse_cyc = pulse_cyc;
    assign bus.o_pulse_upd = pulse_upd;
    assign bus.o_status    = status_q;
    assign bus.o_overrun   = overrun;
    assign bus.dbg_state   = (state == S_TX_LOAD) ? ser_state : state;

endmodule

// File: tb/tb_servo_cmd_ctrl.sv
// Testbench for servo_cmd_ctrl: directed frames, a uart_tx busy model,
// and a scoreboard of expected reply bytes and pulse updates.
// The inter-byte timeout is shortened so the run stays short.
module tb_servo_cmd_ctrl;
    import servo_cmd_ctrl_pkg::*;

    localparam int PULSE_W    = 20;
    localparam int CLK_PER_US = 27;
    localparam int T_CYC      = 300;
    localparam int BUSY_CYC   = 6;

    logic clk = 1'b0;
    logic i_resetn;
    int   checks = 0;
    int   errors = 0;

    logic [7:0]         exp_q[$];
    logic [PULSE_W-1:0] exp_pulse_q[$];

    logic silent    = 1'b0;
    int   tx_starts = 0;

    servo_cmd_ctrl_if #(.PULSE_W(PULSE_W)) bus();

    servo_cmd_ctrl #(
        .CLK_PER_US  (CLK_PER_US),
        .MIN_US      (500),
        .MAX_US      (2500),
        .DEFAULT_US  (1500),
        .TIMEOUT_CYC (T_CYC),
        .PULSE_W     (PULSE_W)
    ) dut (
        .clk      (clk),
        .i_resetn (i_resetn),
        .bus      (bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- uart_tx busy model ----------------
    // Busy rises just after the clock edge that accepted o_tx_en and stays
    // up for BUSY_CYC cycles; in silent mode busy never rises.
    initial begin
        int seen = 0;
        int cnt  = 0;
        bus.i_tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tx_starts != seen) begin
                seen = tx_starts;
                if (!silent) begin
                    bus.i_tx_busy = 1'b1;
                    cnt = BUSY_CYC;
                end
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) bus.i_tx_busy = 1'b0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (i_resetn === 1'b1 && bus.o_tx_en === 1'b1) begin
            tx_starts++;
            check("tx_en_while_busy", 32'(bus.i_tx_busy), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected: got byte 0x%0h, expected no byte", bus.o_tx_data);
            end else begin
                check("tx_byte", 32'(bus.o_tx_data), 32'(exp_q.pop_front()));
            end
        end
        if (bus.o_pulse_upd === 1'b1) begin
            if (exp_pulse_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pulse_unexpected: got update to %0d, expected no update", bus.o_pulse_cyc);
            end else begin
                check("pulse_upd_value", 32'(bus.o_pulse_cyc), 32'(exp_pulse_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.i_rx_valid = 1'b1;
        bus.i_rx_data  = b;
        @(negedge clk);
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l);
        send_byte(c);
        send_byte(h);
        send_byte(l);
    endtask

    task automatic push_reply(input logic [7:0] s, input logic [7:0] h, input logic [7:0] l);
        exp_q.push_back(s);
        exp_q.push_back(h);
        exp_q.push_back(l);
        exp_q.push_back(8'h0A);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (n < 2000 && (exp_q.size() != 0 || exp_pulse_q.size() != 0 ||
                            bus.dbg_state != S_IDLE)) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL %s: reply not complete after %0d cycles, %0d bytes outstanding",
                     name, n, exp_q.size());
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int en_seen;
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = 8'h00;
        i_resetn       = 1'b0;
        repeat (3) @(negedge clk);
        i_resetn = 1'b1;
        @(negedge clk);

        check("rst_pulse_cyc", 32'(bus.o_pulse_cyc), 32'd40500);
        check("rst_tx_en", 32'(bus.o_tx_en), 32'd0);
        check("rst_tx_data", 32'(bus.o_tx_data), 32'd0);
        check("rst_status", 32'(bus.o_status), 32'd0);
        check("rst_overrun", 32'(bus.o_overrun), 32'd0);
        check("rst_pulse_upd", 32'(bus.o_pulse_upd), 32'd0);

        // SET 2000 us with latency check
        exp_pulse_q.push_back(20'd54000);
        push_reply(8'h00, 8'h07, 8'hD0);
        send_frame(8'h01, 8'h07, 8'hD0);
        check("lat_upd_n1", 32'(bus.o_pulse_upd), 32'd0);
        check("lat_tx_en_n1", 32'(bus.o_tx_en), 32'd0);
        @(negedge clk);
        check("lat_upd_n2", 32'(bus.o_pulse_upd), 32'd1);
        check("lat_pulse_n2", 32'(bus.o_pulse_cyc), 32'd54000);
        @(negedge clk);
        check("lat_upd_n3", 32'(bus.o_pulse_upd), 32'd0);
        wait_idle("set_2000");
        check("set_2000_status", 32'(bus.o_status), 32'h00);

        // SET 100 us clamps to 500 us
        exp_pulse_q.push_back(20'd13500);
        push_reply(8'h01, 8'h01, 8'hF4);
        send_frame(8'h01, 8'h00, 8'h64);
        wait_idle("set_clamp_lo");
        check("clamp_lo_status", 32'(bus.o_status), 32'h01);
        check("clamp_lo_pulse", 32'(bus.o_pulse_cyc), 32'd13500);

        // GET returns the current setting, no update
        push_reply(8'h00, 8'h01, 8'hF4);
        send_frame(8'h02, 8'h12, 8'h34);
        wait_idle("get");
        check("get_status", 32'(bus.o_status), 32'h00);
        check("get_pulse_kept", 32'(bus.o_pulse_cyc), 32'd13500);

        // Inter-byte timeout after two bytes
        push_reply(8'hE1, 8'h00, 8'h00);
        send_byte(8'h01);
        send_byte(8'h07);
        wait_idle("timeout");
        check("timeout_pulse_kept", 32'(bus.o_pulse_cyc), 32'd13500);

        // Third byte lands exactly in the last timer cycle: byte wins
        exp_pulse_q.push_back(20'd40500);
        push_reply(8'h00, 8'h05, 8'hDC);
        send_byte(8'h01);
        send_byte(8'h05);
        repeat (T_CYC - 2) @(negedge clk);
        send_byte(8'hDC);
        wait_idle("byte_at_timeout");
        check("byte_at_timeout_pulse", 32'(bus.o_pulse_cyc), 32'd40500);

        // Unknown command, extra byte during the reply
        push_reply(8'hEE, 8'h00, 8'h00);
        send_frame(8'h55, 8'h00, 8'h00);
        check("overrun_before", 32'(bus.o_overrun), 32'd0);
        repeat (3) @(negedge clk);
        send_byte(8'h33);
        wait_idle("bad_cmd");
        check("bad_cmd_status", 32'(bus.o_status), 32'hEE);
        check("overrun_set", 32'(bus.o_overrun), 32'd1);

        // Next frame still parsed; overrun stays sticky
        exp_pulse_q.push_back(20'd27000);
        push_reply(8'h00, 8'h03, 8'hE8);
        send_frame(8'h01, 8'h03, 8'hE8);
        wait_idle("after_overrun");
        check("overrun_sticky", 32'(bus.o_overrun), 32'd1);
        check("after_overrun_pulse", 32'(bus.o_pulse_cyc), 32'd27000);

        // uart_tx that never raises busy: each byte sent after the wait limit
        silent = 1'b1;
        push_reply(8'h00, 8'h03, 8'hE8);
        send_frame(8'h02, 8'h00, 8'h00);
        wait_idle("silent_tx");
        silent = 1'b0;

        // Reset in the middle of a reply, after its first byte
        exp_pulse_q.push_back(20'd54000);
        exp_q.push_back(8'h00);
        send_frame(8'h01, 8'h07, 8'hD0);
        en_seen = 0;
        while (exp_q.size() != 0 && en_seen < 200) begin
            @(negedge clk);
            en_seen++;
        end
        check("mid_reset_first_byte", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        i_resetn = 1'b0;
        en_seen  = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.o_tx_en === 1'b1) en_seen++;
        end
        i_resetn = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (bus.o_tx_en === 1'b1) en_seen++;
        end
        check("mid_reset_no_tx_en", 32'(en_seen), 32'd0);
        check("mid_reset_state", 32'(bus.dbg_state), 32'(S_IDLE));
        check("mid_reset_pulse", 32'(bus.o_pulse_cyc), 32'd40500);
        check("mid_reset_overrun", 32'(bus.o_overrun), 32'd0);
        check("mid_reset_status", 32'(bus.o_status), 32'd0);

        // Frames after reset: exact upper limit, then above it
        exp_pulse_q.push_back(20'd67500);
        push_reply(8'h00, 8'h09, 8'hC4);
        send_frame(8'h01, 8'h09, 8'hC4);
        wait_idle("set_max");
        check("set_max_status", 32'(bus.o_status), 32'h00);

        exp_pulse_q.push_back(20'd67500);
        push_reply(8'h01, 8'h09, 8'hC4);
        send_frame(8'h01, 8'hFF, 8'hFF);
        wait_idle("clamp_hi");
        check("clamp_hi_status", 32'(bus.o_status), 32'h01);

        // Exact lower limit is not a clamp
        exp_pulse_q.push_back(20'd13500);
        push_reply(8'h00, 8'h01, 8'hF4);
        send_frame(8'h01, 8'h01, 8'hF4);
        wait_idle("set_min");
        check("set_min_status", 32'(bus.o_status), 32'h00);

        repeat (5) @(negedge clk);
        check("end_tx_q_empty", 32'(exp_q.size()), 32'd0);
        check("end_pulse_q_empty", 32'(exp_pulse_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
